// File: rtl/tmr_ctrl_pkg.sv
// Shared types for the triplicated-SRAM scrub controller: FSM states, vote classes, depth.
// Pure declarations; no logic, no latency.
package tmr_ctrl_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    U_WR  = 3'd1,
    U_RD  = 3'd2,
    U_CHK = 3'd3,
    U_WB  = 3'd4,
    S_RD  = 3'd5,
    S_CHK = 3'd6,
    S_WB  = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    VOTE_OK     = 2'd0,
    VOTE_CORR   = 2'd1,
    VOTE_UNCORR = 2'd2
  } vote_e;

endpackage

// File: rtl/tmr_scrub_ctrl_if.sv
// User request port of the scrub controller: request/grant command in, one-cycle read-data pulse out.
// The requester holds usr_req until it sees usr_gnt; read data returns three cycles after the grant.
interface tmr_scrub_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              usr_req;
  logic              usr_we;
  logic [ADDR_W-1:0] usr_addr;
  logic [DATA_W-1:0] usr_wdata;
  logic              usr_gnt;
  logic              usr_rvalid;
  logic [DATA_W-1:0] usr_rdata;

  modport master (
    output usr_req, usr_we, usr_addr, usr_wdata,
    input  usr_gnt, usr_rvalid, usr_rdata
  );

  modport slave (
    input  usr_req, usr_we, usr_addr, usr_wdata,
    output usr_gnt, usr_rvalid, usr_rdata
  );
endinterface

// File: rtl/tmr_voter3.sv
// Bitwise majority of three copies plus agreement class; purely combinational, zero latency.
// No flow control: the caller decides when the inputs are meaningful.
module tmr_voter3
  import tmr_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] c_i,
  output logic [DATA_W-1:0] maj_o,
  output vote_e             cls_o
);

  logic ab_eq;
  logic ac_eq;
  logic bc_eq;

  assign ab_eq = (a_i == b_i);
  assign ac_eq = (a_i == c_i);
  assign bc_eq = (b_i == c_i);
  assign maj_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

  always_comb begin
    cls_o = VOTE_UNCORR;
    if (ab_eq && ac_eq) begin
      cls_o = VOTE_OK;
    end else if (ab_eq || ac_eq || bc_eq) begin
      cls_o = VOTE_CORR;
    end
  end

endmodule

// File: rtl/tmr_scrub_ctrl.sv
// Sequences user and scrub accesses to a triplicated SRAM, votes reads and writes back single upsets.
// Read data 3 cycles after grant; grant only in IDLE and withheld while an overdue scrub is forced.
module tmr_scrub_ctrl
  import tmr_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int SCRUB_INTERVAL = 64,
  parameter int MAX_DEFER      = 16,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  tmr_scrub_ctrl_if.slave   usr,
  input  logic              scrub_en,
  input  logic              err_clr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata_1,
  input  logic [DATA_W-1:0] mem_rdata_2,
  input  logic [DATA_W-1:0] mem_rdata_3,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic              uncorr_err,
  output logic [ADDR_W-1:0] uncorr_addr,
  output logic              scrub_done
);

  localparam int IW  = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam int DFW = $clog2(MAX_DEFER + 1);

  state_e            state_q,       state_d;
  logic [ADDR_W-1:0] cmd_addr_q,    cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q,   cmd_wdata_d;
  logic [DATA_W-1:0] maj_q,         maj_d;
  logic [ADDR_W-1:0] ptr_q,         ptr_d;
  logic [IW-1:0]     interval_q,    interval_d;
  logic [DFW-1:0]    defer_q,       defer_d;
  logic              pending_q,     pending_d;
  logic [CNT_W-1:0]  corr_cnt_q,    corr_cnt_d;
  logic              uncorr_err_q,  uncorr_err_d;
  logic [ADDR_W-1:0] uncorr_addr_q, uncorr_addr_d;
  logic [DATA_W-1:0] rdata_q,       rdata_d;
  logic              rvalid_q,      rvalid_d;
  logic              done_q,        done_d;

  logic              force_scrub;
  logic              gnt;
  logic [DATA_W-1:0] vote_maj;
  vote_e             vote_cls;

  tmr_voter3 #(.DATA_W(DATA_W)) u_voter (
    .a_i   (mem_rdata_1),
    .b_i   (mem_rdata_2),
    .c_i   (mem_rdata_3),
    .maj_o (vote_maj),
    .cls_o (vote_cls)
  );

  assign force_scrub = pending_q && (defer_q >= DFW'(MAX_DEFER));
  assign gnt         = !rst && (state_q == IDLE) && usr.usr_req && !force_scrub;

  always_comb begin
    state_d       = state_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_wdata_d   = cmd_wdata_q;
    maj_d         = maj_q;
    ptr_d         = ptr_q;
    interval_d    = interval_q;
    defer_d       = defer_q;
    pending_d     = pending_q;
    corr_cnt_d    = corr_cnt_q;
    uncorr_err_d  = uncorr_err_q;
    uncorr_addr_d = uncorr_addr_q;
    rdata_d       = rdata_q;
    rvalid_d      = 1'b0;
    done_d        = 1'b0;

    // An expiry while a scrub is already pending simply re-sets the flag, i.e. is dropped.
    if (scrub_en) begin
      if (interval_q == IW'(SCRUB_INTERVAL - 1)) begin
        interval_d = '0;
        pending_d  = 1'b1;
      end else begin
        interval_d = interval_q + IW'(1);
      end
    end

    if (gnt && pending_q) begin
      defer_d = defer_q + DFW'(1);
    end

    if (err_clr) begin
      uncorr_err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (gnt) begin
          cmd_addr_d  = usr.usr_addr;
          cmd_wdata_d = usr.usr_wdata;
          state_d     = usr.usr_we ? U_WR : U_RD;
        end else if (pending_q && (!usr.usr_req || force_scrub)) begin
          state_d   = S_RD;
          pending_d = 1'b0;
          defer_d   = '0;
        end
      end
      U_WR:  state_d = IDLE;
      U_RD:  state_d = U_CHK;
      U_CHK: begin
        rdata_d  = vote_maj;
        rvalid_d = 1'b1;
        maj_d    = vote_maj;
        state_d  = IDLE;
        if (vote_cls == VOTE_CORR) begin
          state_d = U_WB;
          if (corr_cnt_q != {CNT_W{1'b1}}) corr_cnt_d = corr_cnt_q + CNT_W'(1);
        end else if (vote_cls == VOTE_UNCORR) begin
          uncorr_err_d  = 1'b1;
          uncorr_addr_d = cmd_addr_q;
        end
      end
      U_WB:  state_d = IDLE;
      S_RD:  state_d = S_CHK;
      S_CHK: begin
        maj_d = vote_maj;
        if (vote_cls == VOTE_CORR) begin
          state_d = S_WB;
          if (corr_cnt_q != {CNT_W{1'b1}}) corr_cnt_d = corr_cnt_q + CNT_W'(1);
        end else begin
          if (vote_cls == VOTE_UNCORR) begin
            uncorr_err_d  = 1'b1;
            uncorr_addr_d = ptr_q;
          end
          state_d = IDLE;
          ptr_d   = ptr_q + ADDR_W'(1);
          done_d  = (ptr_q == {ADDR_W{1'b1}});
        end
      end
      S_WB: begin
        state_d = IDLE;
        ptr_d   = ptr_q + ADDR_W'(1);
        done_d  = (ptr_q == {ADDR_W{1'b1}});
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_addr_q    <= '0;
      cmd_wdata_q   <= '0;
      maj_q         <= '0;
      ptr_q         <= '0;
      interval_q    <= '0;
      defer_q       <= '0;
      pending_q     <= 1'b0;
      corr_cnt_q    <= '0;
      uncorr_err_q  <= 1'b0;
      uncorr_addr_q <= '0;
      rdata_q       <= '0;
      rvalid_q      <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_wdata_q   <= cmd_wdata_d;
      maj_q         <= maj_d;
      ptr_q         <= ptr_d;
      interval_q    <= interval_d;
      defer_q       <= defer_d;
      pending_q     <= pending_d;
      corr_cnt_q    <= corr_cnt_d;
      uncorr_err_q  <= uncorr_err_d;
      uncorr_addr_q <= uncorr_addr_d;
      rdata_q       <= rdata_d;
      rvalid_q      <= rvalid_d;
      done_q        <= done_d;
    end
  end

  // Memory strobes decode straight from the current state, so a reset state never strobes.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      U_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cmd_addr_q;
        mem_wdata = cmd_wdata_q;
      end
      U_RD: begin
        mem_en   = 1'b1;
        mem_addr = cmd_addr_q;
      end
      U_WB: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cmd_addr_q;
        mem_wdata = maj_q;
      end
      S_RD: begin
        mem_en   = 1'b1;
        mem_addr = ptr_q;
      end
      S_WB: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ptr_q;
        mem_wdata = maj_q;
      end
      default: ;
    endcase
  end

  assign usr.usr_gnt    = gnt;
  assign usr.usr_rvalid = rvalid_q;
  assign usr.usr_rdata  = rdata_q;
  assign corr_cnt       = corr_cnt_q;
  assign uncorr_err     = uncorr_err_q;
  assign uncorr_addr    = uncorr_addr_q;
  assign scrub_done     = done_q;

endmodule

// File: doc/tmr_scrub_ctrl.md
Name: tmr_scrub_ctrl

Overview:
- Controller in front of the triplicated 256x8 SRAM (three copies with a majority voter).
- Arbitrates a single user request port against a background scrubber and sequences every memory access.
- Votes the raw copy outputs and writes corrected data back on single-copy upsets, during both user reads and scrub reads.
- Reports corrected and uncorrectable error statistics.

Parameters:
ADDR_W, 8, address width; memory depth is 2**ADDR_W
DATA_W, 8, word width
SCRUB_INTERVAL, 64, cycles between scrub requests while scrub_en=1 (>=2)
MAX_DEFER, 16, user grants allowed while a scrub is pending before the scrub is forced
CNT_W, 16, width of corrected-error counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
usr_req  in  1  user request
usr_we  in  1  1=write, 0=read
usr_addr  in  ADDR_W  user address
usr_wdata  in  DATA_W  user write data
usr_gnt  out  1  request accepted this cycle (combinational)
usr_rvalid  out  1  one-cycle pulse, usr_rdata valid
usr_rdata  out  DATA_W  voted read data
scrub_en  in  1  enables interval timer
err_clr  in  1  clears uncorr_err
mem_en  out  1  memory access strobe
mem_we  out  1  write to all three copies
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  broadcast write data
mem_rdata_1/2/3  in  DATA_W  raw copy outputs, valid the cycle after a read strobe
corr_cnt  out  CNT_W  saturating count of single-copy corrections
uncorr_err  out  1  sticky: no two copies agreed
uncorr_addr  out  ADDR_W  address of the latest uncorrectable event
scrub_done  out  1  pulse when the scrub pointer wraps to 0

Behaviour:
- Reset (rst=1 at posedge), including mid-operation: state=IDLE; all outputs 0; scrub pointer, interval counter, defer counter, pending flag cleared. No memory strobe in the cycle after reset.
- States: IDLE, U_WR, U_RD, U_CHK, U_WB, S_RD, S_CHK, S_WB.
- usr_gnt is asserted only in IDLE. It is 1 when usr_req=1 and the scrub is not being forced. The grant cycle captures the command.
- Scrub start: from IDLE, go to S_RD when pending=1 and either usr_req=0 or defer_cnt>=MAX_DEFER.
  - Entering S_RD clears pending and defer_cnt.
  - defer_cnt increments on every grant made while pending=1.
- Interval timer: counts only while scrub_en=1. It sets pending every SCRUB_INTERVAL cycles. An expiry with pending already set is dropped (not queued).
- U_WR: mem_en=1, mem_we=1 with the captured addr/data, then IDLE.
- U_RD: mem_en=1, mem_we=0, then U_CHK.
- U_CHK: vote the three copies. Register usr_rdata=majority and pulse usr_rvalid, i.e. 3 cycles after usr_gnt.
  - Exactly one copy differs: go to U_WB and increment corr_cnt.
  - No two copies equal: set uncorr_err, record uncorr_addr, go to IDLE.
  - All equal: go to IDLE.
- U_WB: write the majority value to the captured address, then IDLE.
- S_RD / S_CHK / S_WB: same as the user read path, using the scrub pointer. No usr_rvalid.
  - The pointer increments (wrapping DEPTH-1 to 0) when leaving S_CHK without a write-back, or when leaving S_WB.
  - scrub_done pulses for one cycle on the wrap.
- Vote: bitwise majority.
  - Classification: all-equal; single-differ (exactly two copies equal); uncorrectable (no pair equal).
  - Uncorrectable events never write back.
- corr_cnt saturates at 2**CNT_W-1.
- uncorr_err: when err_clr and a new uncorrectable event occur in the same cycle, the event wins (stays 1).
- usr_req held across cycles is not double-accepted: each grant starts one transaction.

Decomposition:
- Package tmr_ctrl_pkg holds:
  - the state enum;
  - the vote-class enum (VOTE_OK, VOTE_CORR, VOTE_UNCORR);
  - the DEPTH constant.
- Sub-module tmr_voter3 is combinational: three inputs, outputs the majority word and the vote class. It is shared by the user and scrub paths.

Test Plan:
1. Reset; write 0x2C to addr 10; read addr 10. Required: usr_rvalid exactly 3 cycles after usr_gnt, usr_rdata=0x2C, corr_cnt=0.
2. Force copy 1 at addr 10 to 0x00, release, then user read. Required: usr_rdata=0x2C, U_WB writes 0x2C to addr 10, corr_cnt=1, copy 1 reads 0x2C afterwards.
3. Preload addr 20 copies with 0xAA/0xBB/0xCC; let the scrubber reach addr 20. Required: uncorr_err=1, uncorr_addr=20, no mem_we at addr 20, corr_cnt unchanged. Then err_clr clears uncorr_err.
4. SCRUB_INTERVAL=4, MAX_DEFER=16, usr_req held high. Required: S_RD entered after exactly 16 grants following pending, and the pointer advances by 1.
5. scrub_en=1, no user traffic, clean memory. Required: after 256 scrubs scrub_done pulses once, pointer=0, corr_cnt=0.
6. Assert rst during S_WB. Required: next cycle state=IDLE, mem_en=0, corr_cnt=0, pointer=0.
